// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its environment: the
// oversample tick, the serial line, the control inputs and everything
// the receiver reports back (byte, strobe, retransmit request, status).
interface uart_rx_if;
  logic       rx_enbl;
  logic       rx;
  logic       p_enbl;
  logic       full;
  logic [7:0] dout;
  logic       wr_enbl;
  logic       fb;
  logic       busy;
  logic       frm_err;
  logic       ovr_err;

  // Environment side: drives the line and controls, observes results.
  modport master (
    output rx_enbl, rx, p_enbl, full,
    input  dout, wr_enbl, fb, busy, frm_err, ovr_err
  );

  // Receiver side.
  modport slave (
    input  rx_enbl, rx, p_enbl, full,
    output dout, wr_enbl, fb, busy, frm_err, ovr_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled deserialiser for start, 8 data bits (LSB
// first), parity slot and stop. Good bytes are strobed into the FIFO;
// corrupted frames raise fb so the transmitter resends its held byte.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic     clk,
  input logic     areset_n,
  uart_rx_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  // Middle of the start bit, measured from the tick that saw it low.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  // Last tick of a bit period; with the half-bit offset this lands mid-bit.
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t          state_q,   state_d;
  logic [TW-1:0]   tick_q,    tick_d;
  logic [2:0]      bit_q,     bit_d;
  logic [7:0]      shreg_q,   shreg_d;
  logic            p_lat_q,   p_lat_d;
  logic            par_err_q, par_err_d;
  logic            fb_q,      fb_d;
  logic [7:0]      dout_q,    dout_d;
  logic            wr_q,      wr_d;
  logic            frm_q,     frm_d;
  logic            ovr_q,     ovr_d;

  // Metastability synchroniser on the incoming line; idles high.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // State, counters, data path and registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      p_lat_q   <= 1'b0;
      par_err_q <= 1'b0;
      fb_q      <= 1'b0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      p_lat_q   <= p_lat_d;
      par_err_q <= par_err_d;
      fb_q      <= fb_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state logic: everything advances on oversample ticks only, while
  // the three status strobes default low so they last a single clock.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    p_lat_d   = p_lat_q;
    par_err_d = par_err_q;
    fb_d      = fb_q;
    dout_d    = dout_q;
    wr_d      = 1'b0;
    frm_d     = 1'b0;
    ovr_d     = 1'b0;

    if (bus.rx_enbl) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end

        S_START: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (!rx_s) begin
              // Confirmed start: from here every sample is mid-bit.
              state_d = S_DATA;
              bit_d   = '0;
              p_lat_d = bus.p_enbl;
              fb_d    = 1'b0;
            end else begin
              // Glitch shorter than half a bit: ignore it silently.
              state_d = S_IDLE;
            end
          end
        end

        S_DATA: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_PARITY;
            end
          end
        end

        S_PARITY: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            // Even parity: slot must equal the XOR of the data bits.
            par_err_d = p_lat_q & (rx_s ^ (^shreg_q));
            state_d   = S_STOP;
          end
        end

        S_STOP: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            // Return to idle mid stop bit so the next start edge is not missed.
            state_d = S_IDLE;
            if (!rx_s) begin
              frm_d = 1'b1;
              fb_d  = 1'b1;
            end else if (par_err_q) begin
              fb_d = 1'b1;
            end else if (bus.full) begin
              ovr_d = 1'b1;
            end else begin
              dout_d = shreg_q;
              wr_d   = 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout    = dout_q;
  assign bus.wr_enbl = wr_q;
  assign bus.fb      = fb_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.frm_err = frm_q;
  assign bus.ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven bit by bit on the serial line,
// a frame-level model predicts the outcome, byte and fb level, and a
// monitor records strobes, busy ticks and the tick at which fb drops.
module tb_uart_rx;
  localparam int OS   = 16;
  localparam int TDIV = 4;    // clocks per oversample tick
  localparam int LAT  = 168;  // ticks from first low sample to stop sample
  localparam int K_WR = 0, K_FRM = 1, K_PAR = 2, K_OVR = 3;

  logic clk = 1'b0;
  logic areset_n;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .areset_n(areset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tick_no  = 0;

  // Monitor record, cleared per scenario.
  int         wr_cnt = 0, frm_cnt = 0, ovr_cnt = 0;
  int         busy_cnt = 0, busy_first = -1, ev_tick = -1, fb_fall_tick = -1;
  logic [7:0] ev_dout = '0;
  logic       fb_prev = 1'b0;

  // Reference model state.
  logic       m_fb   = 1'b0;
  logic [7:0] m_dout = '0;

  // Observe outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.wr_enbl === 1'b1) begin
      wr_cnt++;
      ev_tick = tick_no;
      ev_dout = bus.dout;
    end
    if (bus.frm_err === 1'b1) begin
      frm_cnt++;
      ev_tick = tick_no;
    end
    if (bus.ovr_err === 1'b1) begin
      ovr_cnt++;
      ev_tick = tick_no;
    end
    if (bus.rx_enbl === 1'b1 && bus.busy === 1'b1) begin
      if (busy_cnt == 0) busy_first = tick_no;
      busy_cnt++;
    end
    if (fb_prev === 1'b1 && bus.fb === 1'b0) fb_fall_tick = tick_no;
    fb_prev = bus.fb;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    wr_cnt = 0; frm_cnt = 0; ovr_cnt = 0;
    busy_cnt = 0; busy_first = -1; ev_tick = -1; fb_fall_tick = -1;
  endtask

  // Hold the line at rxv for n ticks; each tick is the last clock of a
  // TDIV-clock period, so the synchronised line is settled by then.
  task automatic run_ticks(input logic rxv, input int n);
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < TDIV; c++) begin
        @(negedge clk);
        bus.rx      = rxv;
        bus.rx_enbl = (c == TDIV - 1);
        if (c == TDIV - 1) tick_no++;
      end
    end
    @(negedge clk);
    bus.rx_enbl = 1'b0;
  endtask

  // One frame; the stop value is held just past its sample point, then
  // the line idles high. p_enbl is scrambled after the start bit.
  task automatic send_frame(input logic [7:0] d, input logic pslot, input logic stopv,
                            input logic pen, input logic fullv, input int idle);
    bus.p_enbl = pen;
    bus.full   = fullv;
    run_ticks(1'b0, OS);
    bus.p_enbl = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) run_ticks(d[i], OS);
    run_ticks(pslot, OS);
    run_ticks(stopv, OS / 2 + 1);
    run_ticks(1'b1, OS / 2 - 1 + idle);
  endtask

  // Frame-level reference: outcome by priority, plus fb and dout levels.
  function automatic int model_frame(input logic [7:0] d, input logic pslot, input logic stopv,
                                     input logic pen, input logic fullv);
    int k;
    m_fb = 1'b0;
    if (!stopv) begin
      k = K_FRM; m_fb = 1'b1;
    end else if (pen && (pslot != (^d))) begin
      k = K_PAR; m_fb = 1'b1;
    end else if (fullv) begin
      k = K_OVR;
    end else begin
      k = K_WR; m_dout = d;
    end
    return k;
  endfunction

  task automatic test_reset();
    areset_n = 1'b1;
    bus.rx = 1'b1; bus.rx_enbl = 1'b0; bus.p_enbl = 1'b0; bus.full = 1'b0;
    #1 areset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.dout, bus.wr_enbl, bus.fb, bus.busy, bus.frm_err, bus.ovr_err} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: dout=%h wr=%b fb=%b busy=%b frm=%b ovr=%b, required all 0",
               bus.dout, bus.wr_enbl, bus.fb, bus.busy, bus.frm_err, bus.ovr_err);
    end
    areset_n = 1'b1;
    run_ticks(1'b1, 20);
    n_checks++;
    if (wr_cnt + frm_cnt + ovr_cnt + busy_cnt !== 0) begin
      n_errors++;
      $display("FAIL reset_idle: strobes=%0d busy_ticks=%0d, required 0", wr_cnt + frm_cnt + ovr_cnt, busy_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int s, k;
    clear_mon();
    s = tick_no + 1;
    k = model_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 10);
    n_checks++;
    if (wr_cnt !== 1 || frm_cnt !== 0 || ovr_cnt !== 0 || ev_dout !== 8'hA5) begin
      n_errors++;
      $display("FAIL basic_write: wr=%0d frm=%0d ovr=%0d dout=%h, required wr=1 dout=a5 (kind %0d)",
               wr_cnt, frm_cnt, ovr_cnt, ev_dout, k);
    end
    n_checks++;
    if (ev_tick !== s + LAT) begin
      n_errors++;
      $display("FAIL basic_latency: strobe at tick %0d, required %0d", ev_tick, s + LAT);
    end
    n_checks++;
    if (busy_first !== s || busy_cnt !== LAT) begin
      n_errors++;
      $display("FAIL basic_busy: first=%0d ticks=%0d, required first=%0d ticks=%0d", busy_first, busy_cnt, s, LAT);
    end
    n_checks++;
    if (bus.fb !== 1'b0 || bus.dout !== m_dout || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_levels: fb=%b dout=%h busy=%b, required fb=0 dout=%h busy=0", bus.fb, bus.dout, bus.busy, m_dout);
    end
    $display("test_basic: byte a5 -> dout %h at tick %0d", ev_dout, ev_tick);
  endtask

  task automatic test_parity();
    int s, k;
    logic [7:0] d;
    logic [2:0] pv;
    d  = 8'h3C;
    pv = 3'b010;  // P slot per frame: good, bad, good
    for (int f = 0; f < 3; f++) begin
      clear_mon();
      s = tick_no + 1;
      k = model_frame(d, pv[f], 1'b1, 1'b1, 1'b0);
      send_frame(d, pv[f], 1'b1, 1'b1, 1'b0, 30);
      n_checks++;
      if (wr_cnt !== int'(k == K_WR) || frm_cnt !== 0 || ovr_cnt !== 0) begin
        n_errors++;
        $display("FAIL parity_events[%0d]: wr=%0d frm=%0d ovr=%0d, required wr=%0d", f, wr_cnt, frm_cnt, ovr_cnt, int'(k == K_WR));
      end
      n_checks++;
      if (bus.fb !== m_fb || bus.dout !== m_dout) begin
        n_errors++;
        $display("FAIL parity_levels[%0d]: fb=%b dout=%h, required fb=%b dout=%h", f, bus.fb, bus.dout, m_fb, m_dout);
      end
      if (f == 2) begin
        n_checks++;
        if (fb_fall_tick !== s + OS / 2) begin
          n_errors++;
          $display("FAIL parity_fb_clear: fb fell at tick %0d, required %0d", fb_fall_tick, s + OS / 2);
        end
      end
      $display("test_parity[%0d]: P=%b kind=%0d wr=%0d fb=%b", f, pv[f], k, wr_cnt, bus.fb);
    end
  endtask

  task automatic test_frame_error();
    int s, k;
    clear_mon();
    s = tick_no + 1;
    k = model_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    n_checks++;
    if (frm_cnt !== 1 || wr_cnt !== 0 || ovr_cnt !== 0 || ev_tick !== s + LAT) begin
      n_errors++;
      $display("FAIL frame_error_events: frm=%0d wr=%0d ovr=%0d tick=%0d, required frm=1 tick=%0d (kind %0d)",
               frm_cnt, wr_cnt, ovr_cnt, ev_tick, s + LAT, k);
    end
    n_checks++;
    if (bus.fb !== 1'b1 || bus.dout !== m_dout) begin
      n_errors++;
      $display("FAIL frame_error_levels: fb=%b dout=%h, required fb=1 dout=%h", bus.fb, bus.dout, m_dout);
    end
    $display("test_frame_error: frm=%0d fb=%b dout=%h", frm_cnt, bus.fb, bus.dout);
  endtask

  task automatic test_false_start();
    int s;
    clear_mon();
    s = tick_no + 1;
    run_ticks(1'b0, 4);
    run_ticks(1'b1, 20);
    n_checks++;
    if (busy_first !== s || busy_cnt !== OS / 2) begin
      n_errors++;
      $display("FAIL false_start_busy: first=%0d ticks=%0d, required first=%0d ticks=%0d", busy_first, busy_cnt, s, OS / 2);
    end
    n_checks++;
    if (wr_cnt + frm_cnt + ovr_cnt !== 0 || bus.fb !== m_fb || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL false_start_quiet: strobes=%0d fb=%b busy=%b, required strobes=0 fb=%b busy=0",
               wr_cnt + frm_cnt + ovr_cnt, bus.fb, bus.busy, m_fb);
    end
    $display("test_false_start: busy ticks=%0d fb=%b", busy_cnt, bus.fb);
  endtask

  task automatic test_overrun();
    int s, k;
    logic [7:0] dv [2];
    dv[0] = 8'h55; dv[1] = 8'h66;
    for (int f = 0; f < 2; f++) begin
      clear_mon();
      s = tick_no + 1;
      k = model_frame(dv[f], 1'b0, 1'b1, 1'b0, (f == 0));
      send_frame(dv[f], 1'b0, 1'b1, 1'b0, (f == 0), 10);
      bus.full = 1'b0;
      n_checks++;
      if (ovr_cnt !== int'(k == K_OVR) || wr_cnt !== int'(k == K_WR) || frm_cnt !== 0 || ev_tick !== s + LAT) begin
        n_errors++;
        $display("FAIL overrun_events[%0d]: ovr=%0d wr=%0d frm=%0d tick=%0d, required kind %0d at tick %0d",
                 f, ovr_cnt, wr_cnt, frm_cnt, ev_tick, k, s + LAT);
      end
      n_checks++;
      if (bus.fb !== m_fb || bus.dout !== m_dout) begin
        n_errors++;
        $display("FAIL overrun_levels[%0d]: fb=%b dout=%h, required fb=%b dout=%h", f, bus.fb, bus.dout, m_fb, m_dout);
      end
      $display("test_overrun[%0d]: byte %h kind=%0d dout=%h", f, dv[f], k, bus.dout);
    end
  endtask

  task automatic test_reset_midframe();
    int s, k;
    logic [7:0] d;
    d = 8'hC3;
    clear_mon();
    bus.p_enbl = 1'b0;
    run_ticks(1'b0, OS);
    for (int i = 0; i < 4; i++) run_ticks(d[i], OS);
    run_ticks(d[4], OS / 2);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midframe_busy: busy=%b, required 1", bus.busy);
    end
    #2 areset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.dout, bus.wr_enbl, bus.fb, bus.busy, bus.frm_err, bus.ovr_err} !== 13'd0) begin
      n_errors++;
      $display("FAIL midframe_async_reset: dout=%h wr=%b fb=%b busy=%b frm=%b ovr=%b, required all 0",
               bus.dout, bus.wr_enbl, bus.fb, bus.busy, bus.frm_err, bus.ovr_err);
    end
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    m_fb = 1'b0;
    m_dout = '0;
    run_ticks(1'b1, 20);
    n_checks++;
    if (wr_cnt + frm_cnt + ovr_cnt !== 0) begin
      n_errors++;
      $display("FAIL midframe_discard: strobes=%0d, required 0", wr_cnt + frm_cnt + ovr_cnt);
    end
    clear_mon();
    s = tick_no + 1;
    k = model_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 10);
    n_checks++;
    if (wr_cnt !== 1 || frm_cnt !== 0 || ovr_cnt !== 0 || bus.dout !== 8'h5A || ev_tick !== s + LAT || bus.fb !== 1'b0) begin
      n_errors++;
      $display("FAIL midframe_recover: wr=%0d frm=%0d ovr=%0d dout=%h tick=%0d fb=%b, required 1 0 0 5a %0d 0 (kind %0d)",
               wr_cnt, frm_cnt, ovr_cnt, bus.dout, ev_tick, s + LAT, bus.fb, k);
    end
    $display("test_reset_midframe: recovered dout=%h", bus.dout);
  endtask

  task automatic test_back_to_back();
    int s, k;
    logic [7:0] d;
    for (int f = 0; f < 3; f++) begin
      d = 8'($urandom_range(0, 255));
      clear_mon();
      s = tick_no + 1;
      k = model_frame(d, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(d, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      n_checks++;
      if (wr_cnt !== 1 || ev_dout !== d || ev_tick !== s + LAT || frm_cnt + ovr_cnt !== 0) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: wr=%0d dout=%h tick=%0d, required wr=1 dout=%h tick=%0d (kind %0d)",
                 f, wr_cnt, ev_dout, ev_tick, d, s + LAT, k);
      end
      $display("test_back_to_back[%0d]: byte %h -> dout %h", f, d, ev_dout);
    end
    run_ticks(1'b1, 10);
  endtask

  task automatic test_break();
    int s;
    clear_mon();
    s = tick_no + 1;
    bus.p_enbl = 1'b0;
    run_ticks(1'b0, 2 * (LAT + 1));
    run_ticks(1'b1, 20);
    m_fb = 1'b1;
    n_checks++;
    if (frm_cnt !== 2 || ev_tick !== s + 2 * LAT + 1 || wr_cnt + ovr_cnt !== 0 || bus.fb !== m_fb) begin
      n_errors++;
      $display("FAIL break: frm=%0d last=%0d wr+ovr=%0d fb=%b, required frm=2 last=%0d wr+ovr=0 fb=1",
               frm_cnt, ev_tick, wr_cnt + ovr_cnt, bus.fb, s + 2 * LAT + 1);
    end
    $display("test_break: framing errors=%0d", frm_cnt);
  endtask

  task automatic test_random();
    int s, k;
    logic [7:0] d;
    logic p, st, pen, fl;
    for (int f = 0; f < 12; f++) begin
      d   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 5) != 0);
      pen = 1'($urandom_range(0, 1));
      p   = pen ? ((^d) ^ ($urandom_range(0, 3) == 0)) : 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 3) == 0);
      clear_mon();
      s = tick_no + 1;
      k = model_frame(d, p, st, pen, fl);
      send_frame(d, p, st, pen, fl, int'($urandom_range(2, 12)));
      bus.full = 1'b0;
      n_checks++;
      if (wr_cnt !== int'(k == K_WR) || frm_cnt !== int'(k == K_FRM) || ovr_cnt !== int'(k == K_OVR)) begin
        n_errors++;
        $display("FAIL random_events[%0d]: wr=%0d frm=%0d ovr=%0d, required kind %0d (d=%h p=%b st=%b pen=%b full=%b)",
                 f, wr_cnt, frm_cnt, ovr_cnt, k, d, p, st, pen, fl);
      end
      if (k != K_PAR) begin
        n_checks++;
        if (ev_tick !== s + LAT) begin
          n_errors++;
          $display("FAIL random_latency[%0d]: tick=%0d, required %0d", f, ev_tick, s + LAT);
        end
      end
      n_checks++;
      if (bus.fb !== m_fb || bus.dout !== m_dout) begin
        n_errors++;
        $display("FAIL random_levels[%0d]: fb=%b dout=%h, required fb=%b dout=%h", f, bus.fb, bus.dout, m_fb, m_dout);
      end
      $display("test_random[%0d]: d=%h p=%b st=%b pen=%b full=%b kind=%0d dout=%h fb=%b",
               f, d, p, st, pen, fl, k, bus.dout, bus.fb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_error();
    test_false_start();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    test_break();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
